sample_capture: RTL
===================

SAMPLE_CAPTURE -- requirements
Module: sample_capture

Interface
REQ-001 Parameter NUM_W, default 5, width of the captured numeric value.
REQ-002 Parameter DEPTH, default 4, FIFO entries; SHALL be a power of two, at least 2.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 en  input  1  capture enable; when 0, no entries are pushed.
REQ-006 x_in  input  1  sampled control bit, treated as 2-state.
REQ-007 num_in  input  NUM_W  sampled numeric value.
REQ-008 out_ready  input  1  consumer accepts the head entry.
REQ-009 clr_ovf  input  1  clears the sticky overflow flag.
REQ-010 out_valid  output  1  head entry present.
REQ-011 out_x  output  1  x field of head entry.
REQ-012 out_num  output  NUM_W  num field of head entry.
REQ-013 count  output  clog2(DEPTH)+1  entries held, 0..DEPTH.
REQ-014 overflow  output  1  sticky: a capture was dropped.

Function
REQ-015 Change detector holds prev_x, prev_num and a primed bit.
REQ-016 Capture event: en=1 and (primed=0 or x_in!=prev_x or num_in!=prev_num).
REQ-017 On a capture event the block SHALL push {x_in, num_in}, load prev_* from the inputs and set primed, all at the same edge.
REQ-018 With en=0, prev_* and primed SHALL hold, so the first enabled cycle compares against the last captured value.
REQ-019 Latency: an event at edge k SHALL make the entry visible at the FIFO tail after edge k; out_valid rises after edge k if the FIFO was empty (no combinational fall-through).
REQ-020 Pop: out_valid=1 and out_ready=1 at an edge removes the head; out_x/out_num then show the next entry.
REQ-021 out_valid SHALL equal (count!=0); outputs are registered or driven directly from FIFO storage.
REQ-022 Push while full without a simultaneous pop: entry dropped, FIFO unchanged, overflow set; prev_* still update.
REQ-023 Push and pop at the same edge when full: both performed, count stays DEPTH.
REQ-024 Push and pop at the same edge when empty: pop ignored (out_valid=0), push stored, count becomes 1.
REQ-025 Read and write pointers SHALL wrap modulo DEPTH.
REQ-026 clr_ovf=1 clears overflow at the edge; clr_ovf together with a drop SHALL leave overflow set (set wins).
REQ-027 out_x/out_num are don't-care while out_valid=0 but SHALL NOT go X after reset.

Reset
REQ-028 rst_n=0 SHALL immediately clear pointers, count=0, out_valid=0, out_x=0, out_num=0, overflow=0, primed=0, prev_x=0, prev_num=0.
REQ-029 Reset mid-stream SHALL discard all entries; the first enabled cycle after release always captures.
REQ-030 Storage array contents need no reset; output muxing must hide them (REQ-027).

Structure
REQ-031 Package sample_capture_pkg SHALL hold NUM_W and DEPTH defaults and the entry width constant (NUM_W+1).
REQ-032 The FIFO SHALL be a separate sub-module capture_fifo (push, pop, full, empty, count); the change detector and overflow flag live in sample_capture.

Verification
REQ-033 Reset, en=1, x_in=0, num_in=0 held 3 cycles -> exactly one entry {0,0}, count=1.
REQ-034 Sequence x_in 0,1,0,1 with num_in=0, out_ready=0 -> 4 entries, x fields 0,1,0,1 in order, count=4.
REQ-035 num_in 0, then 10, then 5'haa (truncates to 10), then 5'o76 (truncates to 30) -> entries 0,10,30 only; repeated 10 not captured.
REQ-036 Fill to DEPTH with out_ready=0, change num_in once more -> overflow=1, count=4, head unchanged; pulse clr_ovf -> overflow=0.
REQ-037 Full FIFO, out_ready=1 and new change same cycle -> count stays 4, head advances, new entry at tail.
REQ-038 Assert rst_n=0 mid-cycle with count=3 -> out_valid and count drop to 0 without waiting for clk; after release an unchanged num_in is captured once.

Source files
------------

// File: rtl/sample_capture_pkg.sv
// Shared defaults and entry-width helper for the sample_capture block.
package sample_capture_pkg;

   localparam int NUM_W_DEF = 5;
   localparam int DEPTH_DEF = 4;
   localparam int ENTRY_W   = NUM_W_DEF + 1;

   // Entry is {x, num}; one extra bit above the numeric field.
   function automatic int entry_w(input int num_w);
      return num_w + 1;
   endfunction

endpackage

// File: rtl/capture_fifo.sv
// Power-of-two FIFO with occupancy count. The head is read straight from
// storage and forced to zero while empty, so stale or uninitialised
// entries never reach the outputs.
module capture_fifo
   import sample_capture_pkg::*;
#(
   parameter int W     = ENTRY_W,
   parameter int DEPTH = DEPTH_DEF,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] wdata,
   output logic [W-1:0] rdata,
   output logic         full,
   output logic         empty,
   output logic [AW:0]  count
);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   cnt;
   logic          do_push;
   logic          do_pop;

   assign empty   = (cnt == '0);
   assign full    = (cnt == (AW+1)'(DEPTH));
   // A pop on an empty FIFO is ignored; a push into a full FIFO only lands
   // when a pop frees the slot at the same edge.
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);

   // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking (<=) so every flop samples
         // pre-edge values; blocking here would create order-dependent races.
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   cnt <= cnt + 1'b1;
            2'b01:   cnt <= cnt - 1'b1;
            default: cnt <= cnt;
         endcase
      end
   end

   // Storage write port.
   // NOTE: the data array is deliberately left out of reset; a reset would
   // block RAM inference and add a wide reset tree for contents nobody reads
   // until they are written (empty-masking below hides them).
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

   assign rdata = empty ? '0 : mem[rd_ptr];
   assign count = cnt;

endmodule

// File: rtl/sample_capture.sv
// Change-triggered sample capture: pushes {x_in, num_in} into a FIFO
// whenever the enabled inputs differ from the last captured pair, with a
// sticky overflow flag for captures dropped on a full FIFO.
module sample_capture
   import sample_capture_pkg::*;
#(
   parameter int NUM_W = NUM_W_DEF,
   parameter int DEPTH = DEPTH_DEF
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     en,
   input  logic                     x_in,
   input  logic [NUM_W-1:0]         num_in,
   input  logic                     out_ready,
   input  logic                     clr_ovf,
   output logic                     out_valid,
   output logic                     out_x,
   output logic [NUM_W-1:0]         out_num,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     overflow
);

   localparam int EW = entry_w(NUM_W);

   logic             prev_x;
   logic [NUM_W-1:0] prev_num;
   logic             primed;
   logic             capture;
   logic             fifo_full;
   logic             fifo_empty;
   logic             drop;
   logic [EW-1:0]    head;

   // Capture when enabled and either unprimed or the inputs changed.
   always_comb begin
      // NOTE: default assignment first so every path drives the signal and
      // no latch is inferred.
      capture = 1'b0;
      if (en && (!primed || (x_in != prev_x) || (num_in != prev_num)))
         capture = 1'b1;
   end

   // Dropped when full and no pop frees a slot at the same edge.
   assign drop = capture & fifo_full & ~(out_ready & ~fifo_empty);

   // Change-detector history; holds while disabled, updates even on a drop.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prev_x   <= 1'b0;
         prev_num <= '0;
         primed   <= 1'b0;
      end else if (capture) begin
         prev_x   <= x_in;
         prev_num <= num_in;
         primed   <= 1'b1;
      end
   end

   // Sticky overflow; a drop at the same edge as a clear keeps it set.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)       overflow <= 1'b0;
      else if (drop)    overflow <= 1'b1;
      else if (clr_ovf) overflow <= 1'b0;
   end

   capture_fifo #(
      .W     (EW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (capture),
      .pop   (out_ready),
      .wdata ({x_in, num_in}),
      .rdata (head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (count)
   );

   assign out_valid = ~fifo_empty;
   assign out_x     = head[EW-1];
   assign out_num   = head[NUM_W-1:0];

endmodule
